axil_bram_slave: RTL and testbench

- AXI4-Lite slave responder that backs a word-addressed block RAM.
- It is the target end of the AXI4-Lite traffic produced by the bfm master VIP in the bram example bench. It accepts writes, which it commits to RAM with byte strobes, and reads, which it returns from RAM with a registered one-cycle access.
- It sits directly on the bfm master interface inside the block-design wrapper and replaces the register-only slave.

---
 rtl/axil_bram_slave.sv | 192 +++++++++++++++++++
 tb/tb_axil_bram_slave.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_bram_slave.sv
// AXI4-Lite slave backed by a byte-strobed word RAM. B is issued 1 cycle after AW+W, R 2 cycles after AR.
// B and R are held until bready/rready; AW/W/AR are not accepted again until the response completes.
module axil_bram_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int MEM_DEPTH          = 16
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready
);

   localparam int              IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
   localparam int              NBYTES      = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [IDX_W:0]  DEPTH_L     = MEM_DEPTH[IDX_W:0];
   localparam logic [1:0]      RESP_OKAY   = 2'b00;
   localparam logic [1:0]      RESP_SLVERR = 2'b10;

   typedef enum logic       {W_IDLE, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_MEM, R_DATA} r_state_t;

   logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];

   w_state_t                      r_w_state;
   logic                          r_aw_got;
   logic                          r_w_got;
   logic [IDX_W-1:0]              r_aw_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
   logic [NBYTES-1:0]             r_wstrb;
   logic                          r_awready;
   logic                          r_wready;
   logic                          r_bvalid;
   logic [1:0]                    r_bresp;

   r_state_t                      r_r_state;
   logic [IDX_W-1:0]              r_ar_idx;
   logic                          r_arready;
   logic                          r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                    r_rresp;

   logic                          w_aw_hs;
   logic                          w_w_hs;
   logic                          w_aw_have;
   logic                          w_w_have;
   logic [IDX_W-1:0]              w_wr_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_data;
   logic [NBYTES-1:0]             w_wr_strb;
   logic                          w_wr_inrange;
   logic                          w_commit;
   logic                          w_rd_inrange;
   logic                          w_unused;

   // A channel accepted on this edge is used directly, so same-cycle AW+W commits without a bubble.
   assign w_aw_hs      = s00_axi_awvalid && r_awready;
   assign w_w_hs       = s00_axi_wvalid && r_wready;
   assign w_aw_have    = r_aw_got || w_aw_hs;
   assign w_w_have     = r_w_got || w_w_hs;
   assign w_wr_idx     = r_aw_got ? r_aw_idx : s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_wr_data    = r_w_got ? r_wdata : s00_axi_wdata;
   assign w_wr_strb    = r_w_got ? r_wstrb : s00_axi_wstrb;
   assign w_wr_inrange = {1'b0, w_wr_idx} < DEPTH_L;
   assign w_commit     = !s00_axi_areset && (r_w_state == W_IDLE) && w_aw_have && w_w_have;
   assign w_rd_inrange = {1'b0, r_ar_idx} < DEPTH_L;
   assign w_unused     = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   always_ff @(posedge s00_axi_aclk) begin
      if (w_commit && w_wr_inrange) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_w_state <= W_IDLE;
         r_aw_got  <= 1'b0;
         r_w_got   <= 1'b0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         case (r_w_state)
            W_IDLE: begin
               if (w_aw_have && w_w_have) begin
                  r_bresp   <= w_wr_inrange ? RESP_OKAY : RESP_SLVERR;
                  r_bvalid  <= 1'b1;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_aw_got  <= 1'b1;
                  r_w_got   <= 1'b1;
                  r_w_state <= W_RESP;
               end else begin
                  if (w_aw_hs) begin
                     r_aw_got <= 1'b1;
                     r_aw_idx <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                  end
                  if (w_w_hs) begin
                     r_w_got <= 1'b1;
                     r_wdata <= s00_axi_wdata;
                     r_wstrb <= s00_axi_wstrb;
                  end
                  r_awready <= !w_aw_have;
                  r_wready  <= !w_w_have;
               end
            end
            W_RESP: begin
               if (s00_axi_bready) begin
                  r_bvalid  <= 1'b0;
                  r_aw_got  <= 1'b0;
                  r_w_got   <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_w_state <= W_IDLE;
               end
            end
         endcase
      end
   end

   // Read in R_MEM samples r_mem before any same-edge write lands: read-before-write.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_r_state <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         case (r_r_state)
            R_IDLE: begin
               r_arready <= 1'b1;
               if (s00_axi_arvalid && r_arready) begin
                  r_ar_idx  <= s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
                  r_arready <= 1'b0;
                  r_r_state <= R_MEM;
               end
            end
            R_MEM: begin
               if (w_rd_inrange) begin
                  r_rdata <= r_mem[r_ar_idx];
                  r_rresp <= RESP_OKAY;
               end else begin
                  r_rdata <= '0;
                  r_rresp <= RESP_SLVERR;
               end
               r_rvalid  <= 1'b1;
               r_r_state <= R_DATA;
            end
            R_DATA: begin
               if (s00_axi_rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_r_state <= R_IDLE;
               end
            end
            default: r_r_state <= R_IDLE;
         endcase
      end
   end

   assign s00_axi_awready = r_awready;
   assign s00_axi_wready  = r_wready;
   assign s00_axi_bvalid  = r_bvalid;
   assign s00_axi_bresp   = r_bresp;
   assign s00_axi_arready = r_arready;
   assign s00_axi_rvalid  = r_rvalid;
   assign s00_axi_rdata   = r_rdata;
   assign s00_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axil_bram_slave.sv
// Directed bench for axil_bram_slave with MEM_DEPTH=15 so address 0x3C is out of range.
module tb_axil_bram_slave;

   logic        clk = 1'b0;
   logic        areset;
   logic [5:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [5:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axil_bram_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (6),
      .MEM_DEPTH          (15)
   ) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_areset  (areset),
      .s00_axi_awaddr  (awaddr),
      .s00_axi_awprot  (awprot),
      .s00_axi_awvalid (awvalid),
      .s00_axi_awready (awready),
      .s00_axi_wdata   (wdata),
      .s00_axi_wstrb   (wstrb),
      .s00_axi_wvalid  (wvalid),
      .s00_axi_wready  (wready),
      .s00_axi_bresp   (bresp),
      .s00_axi_bvalid  (bvalid),
      .s00_axi_bready  (bready),
      .s00_axi_araddr  (araddr),
      .s00_axi_arprot  (arprot),
      .s00_axi_arvalid (arvalid),
      .s00_axi_arready (arready),
      .s00_axi_rdata   (rdata),
      .s00_axi_rresp   (rresp),
      .s00_axi_rvalid  (rvalid),
      .s00_axi_rready  (rready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives AW and W together; blat = 1 means bvalid visible in the cycle right after acceptance.
   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int blat);
      bit aw_done = 0;
      bit w_done  = 0;
      int guard   = 0;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      resp = 2'b11;
      blat = 0;
      while (!(aw_done && w_done) && guard < 20) begin
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready) w_done = 1;
         step();
         guard++;
         if (aw_done) awvalid = 1'b0;
         if (w_done) wvalid = 1'b0;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      blat = 1;
      while (!bvalid && blat < 20) begin
         step();
         blat++;
      end
      n_checks++;
      if (bvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL write_timeout addr=%h: bvalid=%b, required 1", a, bvalid);
      end
      resp = bresp;
      step();
      bready = 1'b0;
   endtask

   // lat counts cycles from AR acceptance; 2 means rvalid in cycle N+2.
   task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
      int guard = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (!arready && guard < 20) begin
         step();
         guard++;
      end
      step();
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 20) begin
         step();
         lat++;
      end
      n_checks++;
      if (rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL read_timeout addr=%h: rvalid=%b, required 1", a, rvalid);
      end
      d = rdata;
      resp = rresp;
      step();
      rready = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (20) step();
      n_checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_hs: aw/w/ar/b/r = %b, required 00000",
                  {awready, wready, arready, bvalid, rvalid});
      end
      n_checks++;
      if ({bresp, rresp, rdata} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h, required 0", bresp, rresp, rdata);
      end
      areset = 1'b0;
      step();
      n_checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_fail++;
         $display("FAIL reset_release: aw/w/ar ready = %b, required 111", {awready, wready, arready});
      end
   endtask

   task automatic test_seq_write_read();
      logic [1:0]  resp;
      logic [31:0] d;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         do_write(6'(4 * i), 32'(i + 1), 4'hF, resp, lat);
         n_checks++;
         if (resp !== 2'b00 || lat != 1) begin
            n_fail++;
            $display("FAIL seq_write[%0d]: bresp=%b lat=%0d, required 00 lat=1", i, resp, lat);
         end
      end
      for (int i = 0; i < 4; i++) begin
         do_read(6'(4 * i), d, resp, lat);
         n_checks++;
         if (d !== 32'(i + 1) || resp !== 2'b00) begin
            n_fail++;
            $display("FAIL seq_read[%0d]: rdata=%h rresp=%b, required %h 00", i, d, resp, 32'(i + 1));
         end
         n_checks++;
         if (lat != 2) begin
            n_fail++;
            $display("FAIL seq_read_lat[%0d]: lat=%0d, required 2", i, lat);
         end
      end
   endtask

   task automatic test_strobe_order();
      logic [1:0]  resp;
      logic [31:0] d;
      int          lat;
      awaddr = 6'h08; wdata = 32'hAABBCCDD; wstrb = 4'h5;
      wvalid = 1'b1; awvalid = 1'b0; bready = 1'b0;
      step();
      wvalid = 1'b0;
      n_checks++;
      if ({awready, wready, bvalid} !== 3'b100) begin
         n_fail++;
         $display("FAIL w_first: aw/w ready,bvalid = %b, required 100", {awready, wready, bvalid});
      end
      step();
      step();
      awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         n_fail++;
         $display("FAIL aw_late: bvalid=%b bresp=%b, required 1 00", bvalid, bresp);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) begin
            n_fail++;
            $display("FAIL bhold[%0d]: bvalid=%b bresp=%b awready=%b, required 1 00 0",
                     i, bvalid, bresp, awready);
         end
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
      n_checks++;
      if (bvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL b_release: bvalid=%b, required 0", bvalid);
      end
      do_read(6'h08, d, resp, lat);
      n_checks++;
      if (d !== 32'h00BB00DD || resp !== 2'b00) begin
         n_fail++;
         $display("FAIL strobe_read: rdata=%h rresp=%b, required 00bb00dd 00", d, resp);
      end
   endtask

   task automatic test_out_of_range();
      logic [1:0]  resp;
      logic [31:0] d;
      int          lat;
      do_write(6'h38, 32'h14141414, 4'hF, resp, lat);
      n_checks++;
      if (resp !== 2'b00) begin
         n_fail++;
         $display("FAIL oor_w14: bresp=%b, required 00", resp);
      end
      do_write(6'h3C, 32'hDEADBEEF, 4'hF, resp, lat);
      n_checks++;
      if (resp !== 2'b10) begin
         n_fail++;
         $display("FAIL oor_write: bresp=%b, required 10", resp);
      end
      do_read(6'h3C, d, resp, lat);
      n_checks++;
      if (d !== 32'h0 || resp !== 2'b10) begin
         n_fail++;
         $display("FAIL oor_read: rdata=%h rresp=%b, required 00000000 10", d, resp);
      end
      do_read(6'h38, d, resp, lat);
      n_checks++;
      if (d !== 32'h14141414 || resp !== 2'b00) begin
         n_fail++;
         $display("FAIL oor_w14_read: rdata=%h rresp=%b, required 14141414 00", d, resp);
      end
   endtask

   task automatic test_collision();
      logic [1:0]  resp;
      logic [31:0] d;
      int          lat;
      araddr = 6'h04; arvalid = 1'b1; rready = 1'b0; bready = 1'b0;
      step();
      arvalid = 1'b0;
      awaddr = 6'h04; wdata = 32'h55; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      n_checks++;
      if ({awready, wready, arready} !== 3'b110) begin
         n_fail++;
         $display("FAIL coll_setup: aw/w/ar ready = %b, required 110", {awready, wready, arready});
      end
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         n_fail++;
         $display("FAIL coll_b: bvalid=%b bresp=%b, required 1 00", bvalid, bresp);
      end
      step();
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h2 || rresp !== 2'b00) begin
         n_fail++;
         $display("FAIL coll_old: rvalid=%b rdata=%h rresp=%b, required 1 00000002 00",
                  rvalid, rdata, rresp);
      end
      rready = 1'b1; bready = 1'b1;
      step();
      rready = 1'b0; bready = 1'b0;
      do_read(6'h04, d, resp, lat);
      n_checks++;
      if (d !== 32'h55 || resp !== 2'b00) begin
         n_fail++;
         $display("FAIL coll_new: rdata=%h rresp=%b, required 00000055 00", d, resp);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0]  resp;
      logic [31:0] d;
      int          lat;
      int          stale = 0;
      awaddr = 6'h00; wdata = 32'h77; wstrb = 4'hF; araddr = 6'h04;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      step();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      step();
      step();
      n_checks++;
      if ({bvalid, rvalid} !== 2'b11) begin
         n_fail++;
         $display("FAIL mid_pending: bvalid,rvalid = %b, required 11", {bvalid, rvalid});
      end
      areset = 1'b1;
      step();
      n_checks++;
      if ({bvalid, rvalid} !== 2'b00) begin
         n_fail++;
         $display("FAIL mid_reset: bvalid,rvalid = %b, required 00", {bvalid, rvalid});
      end
      step();
      areset = 1'b0;
      bready = 1'b1; rready = 1'b1;
      repeat (6) begin
         step();
         if (bvalid || rvalid) stale++;
      end
      bready = 1'b0; rready = 1'b0;
      n_checks++;
      if (stale != 0) begin
         n_fail++;
         $display("FAIL mid_stale: %0d cycles with stale B/R, required 0", stale);
      end
      do_write(6'h08, 32'h99, 4'hF, resp, lat);
      n_checks++;
      if (resp !== 2'b00 || lat != 1) begin
         n_fail++;
         $display("FAIL mid_fresh_w: bresp=%b lat=%0d, required 00 1", resp, lat);
      end
      do_read(6'h08, d, resp, lat);
      n_checks++;
      if (d !== 32'h99 || resp !== 2'b00 || lat != 2) begin
         n_fail++;
         $display("FAIL mid_fresh_r: rdata=%h rresp=%b lat=%0d, required 00000099 00 2", d, resp, lat);
      end
   endtask

   initial begin
      areset = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      #1;
      test_reset();
      test_seq_write_read();
      test_strobe_order();
      test_out_of_range();
      test_collision();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
